// File: rtl/app_div_9bit.sv
// Two-stage pipelined approximate unsigned divider (Mitchell log subtraction).
// Produces q ~= a/b in Q9.8 with a valid/ready handshake on both sides.
module app_div_9bit #(
    parameter int          FRAC_W  = 8,
    parameter logic [16:0] SAT_VAL = 17'h1FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [8:0]  a,
    input  logic [8:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] q,
    output logic        dz
);

    localparam int DATA_W = FRAC_W + 1;
    localparam int Q_W    = DATA_W + FRAC_W;

    function automatic logic [3:0] lead_idx(input logic [DATA_W-1:0] x);
        logic [3:0] k;
        k = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (x[i]) k = 4'(i);
        end
        return k;
    endfunction

    // Bits below the leading one, left-aligned into the mantissa field.
    function automatic logic [FRAC_W-1:0] lead_frac(input logic [DATA_W-1:0] x,
                                                    input logic [3:0]        k);
        logic [DATA_W-1:0] sh;
        sh = x << (4'd8 - k);
        return sh[FRAC_W-1:0];
    endfunction

    // Antilog shift with divide-by-zero saturation; returns {dz, q}.
    function automatic logic [Q_W:0] shift_sat(input logic [DATA_W-1:0] m,
                                               input logic signed [4:0] e,
                                               input logic              za,
                                               input logic              zb);
        logic [Q_W-1:0] mx;
        logic [4:0]     ne;
        logic [Q_W:0]   r;
        mx = {{(Q_W-DATA_W){1'b0}}, m};
        ne = 5'(-e);
        if (zb)
            r = {1'b1, SAT_VAL};
        else if (za)
            r = '0;
        else if (e >= 0)
            r = {1'b0, mx << e[3:0]};
        else
            r = {1'b0, mx >> ne[3:0]};
        return r;
    endfunction

    logic [3:0]              ka, kb;
    logic [FRAC_W-1:0]       fa, fb;
    logic [DATA_W-1:0]       fdiff;
    logic                    borrow;
    logic [DATA_W-1:0]       m_c;
    logic signed [4:0]       e_c;
    logic [Q_W:0]            res_c;

    logic [DATA_W-1:0]       m_p1;
    logic signed [4:0]       e_p1;
    logic                    za_p1, zb_p1, vld_p1;
    logic [Q_W-1:0]          q_p2;
    logic                    dz_p2, vld_p2;

    logic                    adv2, in_xfer;

    always_comb begin
        ka     = lead_idx(a);
        kb     = lead_idx(b);
        fa     = lead_frac(a, ka);
        fb     = lead_frac(b, kb);
        fdiff  = {1'b0, fa} - {1'b0, fb};
        borrow = (fa < fb);
        // On borrow the 9-bit wrap of fa-fb already equals 512+fa-fb.
        m_c    = borrow ? fdiff : {1'b1, fdiff[FRAC_W-1:0]};
        e_c    = $signed({1'b0, ka}) - $signed({1'b0, kb}) - $signed({4'b0, borrow});
    end

    assign res_c = shift_sat(m_p1, e_p1, za_p1, zb_p1);

    assign adv2      = vld_p1 && (!vld_p2 || out_ready);
    assign in_ready  = !vld_p1 || adv2;
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = vld_p2;
    assign q         = q_p2;
    assign dz        = dz_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p1   <= '0;
            e_p1   <= '0;
            za_p1  <= 1'b0;
            zb_p1  <= 1'b0;
            vld_p1 <= 1'b0;
            q_p2   <= '0;
            dz_p2  <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            // stage 1: log-domain subtraction
            if (in_xfer) begin
                m_p1   <= m_c;
                e_p1   <= e_c;
                za_p1  <= (a == '0);
                zb_p1  <= (b == '0);
                vld_p1 <= 1'b1;
            end else if (adv2) begin
                vld_p1 <= 1'b0;
            end
            // stage 2: antilog shift and zero handling
            if (adv2) begin
                q_p2   <= res_c[Q_W-1:0];
                dz_p2  <= res_c[Q_W];
                vld_p2 <= 1'b1;
            end else if (out_ready) begin
                vld_p2 <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_app_div_9bit.sv
// Scoreboard bench for app_div_9bit: directed vectors, backpressure, streaming, reset.
module tb_app_div_9bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  a = '0;
    logic [8:0]  b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [16:0] q;
    logic        dz;

    logic        rand_rdy = 1'b0;
    logic        rdy_set = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [17:0] sb[$];

    localparam logic [17:0] DZ_EXP = {1'b1, 17'h1FFFF};

    app_div_9bit dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .q(q), .dz(dz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_set;
    end

    function automatic int lg2(input int x);
        for (int i = 8; i >= 0; i--)
            if (x >= (1 << i)) return i;
        return 0;
    endfunction

    // Reference: integer-arithmetic Mitchell division, returns {dz, q}.
    function automatic logic [17:0] model(input int ai, input int bi);
        int ka, kb, fa, fb, m, e, r;
        if (bi == 0) return DZ_EXP;
        if (ai == 0) return 18'd0;
        ka = lg2(ai);
        kb = lg2(bi);
        fa = (ai - (1 << ka)) * (1 << (8 - ka));
        fb = (bi - (1 << kb)) * (1 << (8 - kb));
        if (fa >= fb) begin m = 256 + fa - fb; e = ka - kb; end
        else begin m = 512 + fa - fb; e = ka - kb - 1; end
        if (e >= 0) r = m * (1 << e);
        else r = m / (1 << (-e));
        return {1'b0, 17'(r)};
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic monitor();
        logic [17:0] exp;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got q=%0d dz=%0d, expected no output", q, dz);
                end else begin
                    exp = sb[0];
                    if ({dz, q} !== exp) begin
                        errors++;
                        $display("FAIL result: got q=%0d dz=%0d, expected q=%0d dz=%0d",
                                 q, dz, exp[16:0], exp[17]);
                    end
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    endtask

    // Presents a pair and holds it until accepted; returns just after the accepting edge.
    task automatic send(input logic [8:0] ta, input logic [8:0] tbv, input logic [17:0] exp);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        in_valid = 1'b1;
        a = ta;
        b = tbv;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                done = 1;
            end else begin
                n++;
                if (n > 200) begin
                    chk("accept_timeout", 0, 1);
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain_remaining", sb.size(), 0);
        #1;
    endtask

    initial begin
        fork
            monitor();
        join_none

        // reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q", q, 0);
        chk("rst_dz", dz, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        rdy_set = 1'b1;
        @(posedge clk);
        #1;

        // directed vectors, out_ready high
        send(9'd100, 9'd10, 18'd2688);
        send(9'd10, 9'd100, 18'd27);
        send(9'd511, 9'd1, 18'd130816);
        send(9'd1, 9'd511, 18'd0);
        send(9'd0, 9'd5, 18'd0);
        send(9'd7, 9'd0, DZ_EXP);
        send(9'd0, 9'd0, DZ_EXP);
        send(9'd64, 9'd8, 18'd2048);
        in_valid = 1'b0;
        drain();

        // backpressure: two accepted, third held
        rdy_set = 1'b0;
        @(posedge clk);
        #1;
        send(9'd100, 9'd10, 18'd2688);
        send(9'd10, 9'd100, 18'd27);
        in_valid = 1'b1;
        a = 9'd64;
        b = 9'd8;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #1;
        rdy_set = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1);
        sb.push_back(18'd2048);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // streaming with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 50; i++) begin
            logic [8:0] ra, rb;
            ra = 9'($urandom_range(0, 511));
            rb = (i % 13 == 5) ? 9'd0 : 9'($urandom_range(0, 511));
            if (i % 17 == 3) ra = 9'd0;
            send(ra, rb, model(int'(ra), int'(rb)));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        rdy_set = 1'b1;
        drain();

        // reset with both stages full
        rdy_set = 1'b0;
        @(posedge clk);
        #1;
        send(9'd100, 9'd10, 18'd2688);
        send(9'd10, 9'd100, 18'd27);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_q", q, 0);
        chk("async_rst_dz", dz, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        rdy_set = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(9'd7, 9'd0, DZ_EXP);
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_cycle1", out_valid, 0);
        @(negedge clk);
        chk("latency_cycle2", out_valid, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/app_div_9bit.md
Name: app_div_9bit

Overview:
- Pipelined approximate unsigned divider: q ≈ a / b for 9-bit operands, using Mitchell logarithmic subtraction.
- Inverse companion of the approximate multiplier in the LIF neuron datapath. Used for normalisation and leak scaling, where an exact divider is too large for the tile.
- Two register stages with a valid/ready handshake on both sides, so it can sit between the neuron update logic and a stalling consumer.
- Result is unsigned fixed point Q9.8.

Parameters:
- FRAC_W, 8, fraction bits of the log mantissa and of the output. Fixed at 8; the bench checks only this value.
- SAT_VAL, 17'h1FFFF, output value driven on divide-by-zero.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair a/b present
- in_ready  out  1  block accepts operands this cycle
- a  in  9  dividend, unsigned
- b  in  9  divisor, unsigned
- out_valid  out  1  q/dz valid
- out_ready  in  1  consumer accepts result this cycle
- q  out  17  quotient, unsigned Q9.8 (q/256 ≈ a/b)
- dz  out  1  divide-by-zero flag for this result

Behaviour:
- Reset (async assert, sync-safe release): both stage valid bits = 0, out_valid = 0, q = 0, dz = 0. Internal pipeline registers are cleared to 0.
- Reset mid-operation discards all in-flight results. No output appears after reset until new operands are accepted.

Leading-one extraction, per operand x ≠ 0:
- k = index of the most significant 1 (0..8).
- f = low 8 bits of (x << (8−k)); these are the bits below the leading one, left-aligned.

Stage 1 (registered on transfer in):
- If fa ≥ fb: m = {1'b1, fa−fb} (9 bits), e = ka−kb.
- Else: m = 256 + 256 + fa − fb (fits in 9 bits, bit8 = 1), e = ka−kb−1.
- e is signed 5-bit, range −9..+8.
- Also register za = (a == 0) and zb = (b == 0).

Stage 2 (registered on transfer in):
- If zb: q = SAT_VAL, dz = 1. This holds even when a is also 0.
- Else if za: q = 0, dz = 0.
- Else if e ≥ 0: q = m << e.
- Else: q = m >> (−e), truncating.
- Maximum q = 511 << 8 = 130816, so no overflow is possible.

Handshake and flow:
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- adv2 = v1 && (!v2 || out_ready).
- in_ready = !v1 || adv2. This is a combinational path from out_ready.
- On adv2: stage 2 loads and v2 is set to 1. Otherwise, if out_ready && v2, v2 is cleared to 0.
- Stage 1 loads on an input transfer and v1 is set to 1. Otherwise, if adv2, v1 is cleared to 0.
- out_valid = v2. q and dz are held stable while out_valid && !out_ready.
- Latency: a result is presented 2 cycles after the input transfer when there is no stall.
- Throughput: 1 result per cycle with out_ready held high.
- Capacity: 2 results. in_ready is low only when both stages are full and out_ready is low.
- Simultaneous input and output transfer in the same cycle with both stages full: both complete, and the pipeline shifts by one.
- Results leave in strict input order. None are dropped or duplicated.
- in_valid while in_ready is low: the operands are ignored, and the producer holds them.

Test Plan:
- a=100, b=10, out_ready=1 → 2 cycles after accept: q=2688 (10.5), dz=0. Internal values: fa=144, fb=64, m=336, e=3.
- a=10, b=100 → q=27 (≈0.105), dz=0. This exercises the borrow path: m=432, e=−4.
- a=511, b=1 → q=130816. a=1, b=511 → m=257, e=−9, q=0. a=0, b=5 → q=0, dz=0.
- a=7, b=0 → q=17'h1FFFF, dz=1. a=0, b=0 → q=17'h1FFFF, dz=1.
- Backpressure: out_ready=0, then offer 3 back-to-back pairs (100/10, 10/100, 64/8).
  - in_ready drops after 2 accepts; the third pair is held by the producer.
  - Raise out_ready → outputs are 2688, 27, 2048 in order, with q stable while stalled. The third pair is accepted on the release cycle.
- Streaming: 50 random pairs with out_ready toggled randomly.
  - Every q matches the Mitchell reference model bit-exactly.
  - The count and order of outputs match the inputs.
- Reset: assert rst_n=0 with both stages full → out_valid=0, q=0 immediately (asynchronously).
  - After release, no stale result appears.
  - The next accept produces its result 2 cycles later.
